// File: rtl/dwt_pkg.sv
// Shared DWT definitions: level width, level ceiling and the level sequencer states.
package dwt_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL_DEF = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Limit a requested decomposition level to the supported ceiling.
  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl,
                                                     input logic [LEVEL_W-1:0] max_lvl);
    return (lvl > max_lvl) ? max_lvl : lvl;
  endfunction

endpackage

// File: rtl/dwt_level_sequencer.sv
// Sequences the DWT engine through one pass per decomposition level for each frame.
// Level changes are staged in a pending register and only take effect at frame start.
module dwt_level_sequencer
  import dwt_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] MAX_LEVEL     = MAX_LEVEL_DEF,
  parameter logic [LEVEL_W-1:0] DEFAULT_LEVEL = 4'd0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_update,
  input  logic               frame_start,
  input  logic               pass_done,
  output logic               pass_start,
  output logic [LEVEL_W-1:0] pass_index,
  output logic [LEVEL_W-1:0] active_level,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_overrun
);

  seq_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] pending_level_q, pending_level_d;
  logic [LEVEL_W-1:0] active_level_q, active_level_d;
  logic [LEVEL_W-1:0] pass_index_q, pass_index_d;
  logic               pass_start_q, pass_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_overrun_q, frame_overrun_d;

  logic [LEVEL_W-1:0] new_level;
  logic [LEVEL_W-1:0] frame_level;
  logic [LEVEL_W-1:0] pass_index_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      pending_level_q <= DEFAULT_LEVEL;
      active_level_q  <= DEFAULT_LEVEL;
      pass_index_q    <= '0;
      pass_start_q    <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_level_q <= pending_level_d;
      active_level_q  <= active_level_d;
      pass_index_q    <= pass_index_d;
      pass_start_q    <= pass_start_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  // Next state plus registered-output decode; outputs follow the state being entered.
  always_comb begin
    state_d         = state_q;
    pending_level_d = pending_level_q;
    active_level_d  = active_level_q;
    pass_index_d    = pass_index_q;

    new_level      = clamp_level(level, MAX_LEVEL);
    frame_level    = level_update ? new_level : pending_level_q;
    pass_index_inc = LEVEL_W'(pass_index_q + LEVEL_W'(1));

    if (level_update) begin
      pending_level_d = new_level;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          active_level_d = frame_level;
          pass_index_d   = '0;
          state_d        = (frame_level == '0) ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pass_done) begin
          if (pass_index_inc == active_level_q) begin
            state_d = ST_DONE;
          end else begin
            pass_index_d = pass_index_inc;
            state_d      = ST_START;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pass_start_d    = (state_d == ST_START);
    busy_d          = (state_d != ST_IDLE);
    frame_done_d    = (state_d == ST_DONE);
    frame_overrun_d = frame_start && (state_q != ST_IDLE);
  end

  assign pass_start    = pass_start_q;
  assign pass_index    = pass_index_q;
  assign active_level  = active_level_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_dwt_level_sequencer.sv
// Directed self-checking bench for dwt_level_sequencer with hand-computed expectations.
module tb_dwt_level_sequencer;

  logic       clk;
  logic       reset_n;
  logic [3:0] level;
  logic       level_update;
  logic       frame_start;
  logic       pass_done;
  logic       pass_start;
  logic [3:0] pass_index;
  logic [3:0] active_level;
  logic       busy;
  logic       frame_done;
  logic       frame_overrun;

  int checks = 0;
  int errors = 0;

  dwt_level_sequencer dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .level        (level),
    .level_update (level_update),
    .frame_start  (frame_start),
    .pass_done    (pass_done),
    .pass_start   (pass_start),
    .pass_index   (pass_index),
    .active_level (active_level),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable and new inputs apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_level(input logic [3:0] lvl);
    level        = lvl;
    level_update = 1'b1;
    tick();
    level_update = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Expects to be in the pass_start cycle of pass idx; finishes with pass_done sampled.
  task automatic do_pass(input int idx, input bit last);
    chk("pass_start_hi", 4'(pass_start), 4'd1);
    chk("pass_index", pass_index, 4'(idx));
    tick();
    chk("pass_start_lo", 4'(pass_start), 4'd0);
    tick();
    chk("wait_holds", 4'(busy), 4'd1);
    pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    if (last) begin
      chk("frame_done_hi", 4'(frame_done), 4'd1);
      chk("done_no_pass", 4'(pass_start), 4'd0);
      chk("done_index_hold", pass_index, 4'(idx));
      tick();
      chk("frame_done_lo", 4'(frame_done), 4'd0);
      chk("busy_lo", 4'(busy), 4'd0);
    end
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) do_pass(i, i == n - 1);
  endtask

  initial begin
    reset_n      = 1'b1;
    level        = 4'd0;
    level_update = 1'b0;
    frame_start  = 1'b0;
    pass_done    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 4'(busy), 4'd0);
    chk("rst_active", active_level, 4'd0);
    chk("rst_index", pass_index, 4'd0);
    chk("rst_pulses", {1'b0, pass_start, frame_done, frame_overrun}, 4'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Stray pass_done while idle does nothing.
    pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    chk("idle_pass_done_busy", 4'(busy), 4'd0);
    chk("idle_pass_done_ps", 4'(pass_start), 4'd0);

    // Level 3 frame.
    set_level(4'd3);
    chk("pending_not_active", active_level, 4'd0);
    start_frame();
    chk("l3_active", active_level, 4'd3);
    chk("l3_busy", 4'(busy), 4'd1);
    run_frame(3);
    chk("l3_active_after", active_level, 4'd3);

    // Level 0 frame: immediate done, no pass.
    set_level(4'd0);
    start_frame();
    chk("l0_done", 4'(frame_done), 4'd1);
    chk("l0_busy", 4'(busy), 4'd1);
    chk("l0_no_pass", 4'(pass_start), 4'd0);
    chk("l0_active", active_level, 4'd0);
    tick();
    chk("l0_busy_drop", 4'(busy), 4'd0);
    chk("l0_done_drop", 4'(frame_done), 4'd0);

    // Level update coincident with frame_start uses the new level.
    level        = 4'd1;
    level_update = 1'b1;
    frame_start  = 1'b1;
    tick();
    level_update = 1'b0;
    frame_start  = 1'b0;
    chk("simul_active", active_level, 4'd1);
    run_frame(1);

    // Clamp 15 -> 10.
    set_level(4'd15);
    start_frame();
    chk("clamp_active", active_level, 4'd10);
    run_frame(10);

    // Level change mid-frame only affects the following frame.
    set_level(4'd2);
    start_frame();
    tick();
    level        = 4'd5;
    level_update = 1'b1;
    tick();
    level_update = 1'b0;
    chk("midframe_active", active_level, 4'd2);
    pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    do_pass(1, 1'b1);
    start_frame();
    chk("next_active", active_level, 4'd5);
    run_frame(5);

    // Overrun while waiting.
    set_level(4'd3);
    start_frame();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("overrun_hi", 4'(frame_overrun), 4'd1);
    chk("overrun_index", pass_index, 4'd0);
    chk("overrun_no_pass", 4'(pass_start), 4'd0);
    chk("overrun_busy", 4'(busy), 4'd1);
    tick();
    chk("overrun_lo", 4'(frame_overrun), 4'd0);
    pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    do_pass(1, 1'b0);
    do_pass(2, 1'b1);
    chk("overrun_idle_none", 4'(frame_overrun), 4'd0);

    // Reset during WAIT of pass 1.
    set_level(4'd3);
    start_frame();
    tick();
    pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    tick();
    chk("pre_rst_index", pass_index, 4'd1);
    reset_n = 1'b0;
    #1;
    chk("async_busy", 4'(busy), 4'd0);
    chk("async_index", pass_index, 4'd0);
    chk("async_active", active_level, 4'd0);
    chk("async_pulses", {1'b0, pass_start, frame_done, frame_overrun}, 4'd0);
    tick();
    chk("rst_no_done", 4'(frame_done), 4'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_no_done", 4'(frame_done), 4'd0);
    // Pending level returned to default 0, so this frame completes immediately.
    start_frame();
    chk("post_rst_l0_done", 4'(frame_done), 4'd1);
    tick();
    set_level(4'd2);
    start_frame();
    run_frame(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
